// File: rtl/vref_seq_pkg.sv
// Shared types and constants for the bandgap reference sequencer.
package vref_seq_pkg;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StStart  = 2'd1,
    StSettle = 2'd2,
    StValid  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_BG_BUF  = 2'd0;
  localparam logic [1:0] MODE_EXT_BUF = 2'd1;
  localparam logic [1:0] MODE_IOUT    = 2'd2;

  localparam logic [7:0] TRIM_RESET = 8'h80;

  // Returns {sw1, sw2}; the reserved mode decodes like MODE_BG_BUF.
  function automatic logic [1:0] mode_sw(logic [1:0] mode);
    case (mode)
      MODE_BG_BUF:  return 2'b01;
      MODE_EXT_BUF: return 2'b11;
      MODE_IOUT:    return 2'b00;
      default:      return 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/vref_trim_ramp.sv
// Applied-trim stage: one-LSB soft-start stepper when VREF_SEQ_SOFTSTART_EN is defined,
// otherwise a single-register passthrough.
module vref_trim_ramp
  import vref_seq_pkg::*;
#(
  parameter int unsigned RAMP_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] target,
  output logic [7:0] trim,
  output logic       at_target
);

  logic [7:0] trim_q, trim_d;

`ifdef VREF_SEQ_SOFTSTART_EN
  localparam logic [15:0] RAMP_LIM = 16'((RAMP_CYC > 1) ? RAMP_CYC - 1 : 0);

  logic [15:0] rcnt_q, rcnt_d;

  always_comb begin
    trim_d = trim_q;
    rcnt_d = rcnt_q;
    if (clr) begin
      trim_d = TRIM_RESET;
      rcnt_d = '0;
    end else if (trim_q == target) begin
      rcnt_d = '0;
    end else if (rcnt_q >= RAMP_LIM) begin
      // Stepping from the current code means a retarget mid-ramp needs no special case.
      rcnt_d = '0;
      trim_d = (trim_q < target) ? trim_q + 8'd1 : trim_q - 8'd1;
    end else begin
      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign at_target = (trim_q == target);
`else
  logic unused_cfg;
  assign unused_cfg = clr ^ (RAMP_CYC == 0);
  assign trim_d     = target;
  assign at_target  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trim_q <= TRIM_RESET;
    else        trim_q <= trim_d;
  end

  assign trim = trim_q;

endmodule

// File: rtl/vref_seq.sv
// Bandgap reference power-up / re-settle sequencer. Optional soft-start trim ramp is
// enabled with the VREF_SEQ_SOFTSTART_EN macro.
module vref_seq
  import vref_seq_pkg::*;
#(
  parameter int unsigned START_CYC  = 1024,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned RAMP_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [7:0] i_trim,
  input  logic       i_trim_we,
  input  logic [1:0] i_mode,
  output logic       o_bg_en,
  output logic [7:0] o_trim,
  output logic       o_sw1,
  output logic       o_sw2,
  output logic       o_valid,
  output logic       o_busy,
  output logic [1:0] o_state
);

  // A 0 or 1 cycle setting still spends one cycle in the state.
  localparam logic [CNT_W-1:0] START_LIM  = CNT_W'((START_CYC > 1) ? START_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'((SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       trim_q;
  logic             sw1_q, sw2_q;
  logic [1:0]       sw_d;
  logic             evt, ramp_done;

  assign sw_d    = mode_sw(i_mode);
  assign evt     = i_trim_we | (sw_d != {sw1_q, sw2_q});
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        cnt_d = '0;
        if (i_en) state_d = StStart;
      end
      StStart: begin
        if (cnt_q >= START_LIM && ramp_done) begin
          state_d = StValid;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSettle: begin
        if (evt) begin
          cnt_d = '0;
        end else if (cnt_q >= SETTLE_LIM && ramp_done) begin
          state_d = StValid;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StValid: begin
        if (evt) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      default: state_d = StOff;
    endcase
    if (!i_en) begin
      state_d = StOff;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      trim_q  <= TRIM_RESET;
      sw1_q   <= 1'b0;
      sw2_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (i_trim_we) trim_q <= i_trim;
      {sw1_q, sw2_q} <= sw_d;
    end
  end

  vref_trim_ramp #(
    .RAMP_CYC(RAMP_CYC)
  ) u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_d == StOff),
    .target   (trim_q),
    .trim     (o_trim),
    .at_target(ramp_done)
  );

  assign o_bg_en = (state_q != StOff);
  assign o_valid = (state_q == StValid);
  assign o_busy  = (state_q == StStart) || (state_q == StSettle);
  assign o_state = state_q;
  assign o_sw1   = sw1_q;
  assign o_sw2   = sw2_q;

endmodule

// File: tb/tb_vref_seq.sv
// Directed self-checking bench for vref_seq with default parameters (soft-start off).
module tb_vref_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] trim = 8'h00;
  logic       trim_we = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       bg_en, sw1, sw2, valid, busy;
  logic [7:0] trim_out;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  vref_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en),
    .i_trim   (trim),
    .i_trim_we(trim_we),
    .i_mode   (mode),
    .o_bg_en  (bg_en),
    .o_trim   (trim_out),
    .o_sw1    (sw1),
    .o_sw2    (sw2),
    .o_valid  (valid),
    .o_busy   (busy),
    .o_state  (state)
  );

  // Counts edges until o_valid rises, bounded so a stuck DUT still reaches the summary.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!valid && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bg_en, valid, busy, sw1, sw2} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00001", {bg_en, valid, busy, sw1, sw2});
    end
    checks++;
    if (trim_out !== 8'h80) begin
      errors++; $display("FAIL reset_trim: got %h expected 80", trim_out);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || bg_en !== 1'b0) begin
      errors++; $display("FAIL idle_off: got state %0d bg_en %b expected 0 0", state, bg_en);
    end
  endtask

  task automatic test_start();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (bg_en !== 1'b1 || state !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_entry: got bg_en %b state %0d busy %b expected 1 1 1", bg_en, state, busy);
    end
    wait_valid(n);
    checks++;
    if (n !== 1024) begin
      errors++; $display("FAIL start_len: got %0d expected 1024", n);
    end
    checks++;
    if (state !== 2'd3 || busy !== 1'b0 || trim_out !== 8'h80) begin
      errors++;
      $display("FAIL start_valid: got state %0d busy %b trim %h expected 3 0 80", state, busy, trim_out);
    end
  endtask

  task automatic test_trim_write();
    trim = 8'h5A;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    checks++;
    if (valid !== 1'b0 || state !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL trim_settle: got valid %b state %0d busy %b expected 0 2 1", valid, state, busy);
    end
    @(negedge clk);
    checks++;
    if (trim_out !== 8'h5A) begin
      errors++; $display("FAIL trim_out: got %h expected 5a", trim_out);
    end
    wait_valid(n);
    checks++;
    if (n !== 255) begin
      errors++; $display("FAIL trim_len: got %0d expected 255", n);
    end
  endtask

  task automatic test_rewrite();
    trim = 8'h11;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    repeat (199) @(negedge clk);
    trim = 8'h22;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    checks++;
    if (valid !== 1'b0 || state !== 2'd2) begin
      errors++; $display("FAIL rewrite_200: got valid %b state %0d expected 0 2", valid, state);
    end
    repeat (99) @(negedge clk);
    trim = 8'h33;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    wait_valid(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL rewrite_len: got %0d expected 256", n);
    end
    checks++;
    if (trim_out !== 8'h33) begin
      errors++; $display("FAIL rewrite_trim: got %h expected 33", trim_out);
    end
  endtask

  task automatic test_mode();
    // 0 -> 1 together with a trim write: one re-settle only.
    mode = 2'd1;
    trim = 8'h44;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    checks++;
    if ({sw1, sw2} !== 2'b11 || state !== 2'd2) begin
      errors++; $display("FAIL mode1: got sw %b state %0d expected 11 2", {sw1, sw2}, state);
    end
    wait_valid(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL mode1_len: got %0d expected 256", n);
    end
    mode = 2'd2;
    @(negedge clk);
    checks++;
    if ({sw1, sw2} !== 2'b00 || state !== 2'd2) begin
      errors++; $display("FAIL mode2: got sw %b state %0d expected 00 2", {sw1, sw2}, state);
    end
    wait_valid(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL mode2_len: got %0d expected 256", n);
    end
    mode = 2'd3;
    @(negedge clk);
    checks++;
    if ({sw1, sw2} !== 2'b01 || state !== 2'd2) begin
      errors++; $display("FAIL mode3: got sw %b state %0d expected 01 2", {sw1, sw2}, state);
    end
    wait_valid(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("FAIL mode3_len: got %0d expected 256", n);
    end
    mode = 2'd0;
    @(negedge clk);
    checks++;
    if ({sw1, sw2} !== 2'b01 || state !== 2'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL mode0_noresettle: got sw %b state %0d valid %b expected 01 3 1",
               {sw1, sw2}, state, valid);
    end
  endtask

  task automatic test_disable_start();
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || valid !== 1'b0 || bg_en !== 1'b0) begin
      errors++;
      $display("FAIL off_from_valid: got state %0d valid %b bg_en %b expected 0 0 0", state, valid, bg_en);
    end
    en = 1'b1;
    @(negedge clk);
    repeat (499) @(negedge clk);
    en = 1'b0;
    trim = 8'hA5;
    trim_we = 1'b1;
    @(negedge clk);
    trim_we = 1'b0;
    checks++;
    if (state !== 2'd0 || bg_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_start: got state %0d bg_en %b busy %b valid %b expected 0 0 0 0",
               state, bg_en, busy, valid);
    end
    @(negedge clk);
    checks++;
    if (trim_out !== 8'hA5) begin
      errors++; $display("FAIL abort_trim: got %h expected a5", trim_out);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (bg_en !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL restart_entry: got bg_en %b state %0d expected 1 1", bg_en, state);
    end
    wait_valid(n);
    checks++;
    if (n !== 1024) begin
      errors++; $display("FAIL restart_len: got %0d expected 1024", n);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    @(negedge clk);
    checks++;
    if (sw1 !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL pre_reset: got sw1 %b state %0d expected 1 2", sw1, state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bg_en, valid, busy, sw1, sw2} !== 5'b00001 || state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got flags %b state %0d expected 00001 0",
               {bg_en, valid, busy, sw1, sw2}, state);
    end
    checks++;
    if (trim_out !== 8'h80) begin
      errors++; $display("FAIL async_reset_trim: got %h expected 80", trim_out);
    end
    en = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_trim_write();
    test_rewrite();
    test_mode();
    test_disable_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vref_seq.md
Name: vref_seq

Overview:
- Power-up and reconfiguration sequencer for the 3.3 V bandgap reference, its test buffer and its two analog SPDT switches.
- Sits in the 1.8 V domain between the SPI trim register file and the level shifters. It drives bandgap enable, the 8-bit trim code and both switch selects.
- Reports a "reference valid" flag only after programmable settle intervals.
- Changing trim or measurement mode always forces a re-settle before the reference is reported valid again.

Parameters:
- START_CYC, 1024, clk cycles from bandgap enable to first valid reference.
- SETTLE_CYC, 256, clk cycles after any trim or mode change before valid.
- CNT_W, 12, settle counter width; must hold max(START_CYC, SETTLE_CYC).
- RAMP_CYC, 16, clk cycles per trim LSB step; used only with the soft-start option.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  level request: 1 = reference on, 0 = off
- i_trim  in  8  target trim code from the SPI register
- i_trim_we  in  1  one-cycle strobe: capture i_trim
- i_mode  in  2  measurement mode: 0 = bg to pad via buffer, 1 = external ua1 via buffer, 2 = bg current out, 3 = reserved (treated as 0)
- o_bg_en  out  1  bandgap enable (to level shifter)
- o_trim  out  8  applied trim code (to level shifters)
- o_sw1  out  1  switch 1 select: 1 = ina (external), 0 = inb (bg)
- o_sw2  out  1  switch 2 select: 1 = ina (buffer), 0 = inb (iout)
- o_valid  out  1  reference settled and stable
- o_busy  out  1  in START or SETTLE
- o_state  out  2  current state encoding

Behaviour:
- Reset values: o_bg_en=0, o_trim=8'h80, o_sw1=0, o_sw2=1, o_valid=0, o_busy=0, o_state=OFF. Internal counter=0, trim register=8'h80.
- States and encoding: OFF=0, START=1, SETTLE=2, VALID=3.
- OFF:
  - o_bg_en=0, counter held at 0.
  - i_en=1 moves to START on the next edge; o_bg_en rises in that same edge.
- START:
  - Counter increments each cycle.
  - When counter reaches START_CYC-1, go to VALID. o_valid rises exactly START_CYC cycles after o_bg_en rose.
- SETTLE: counts to SETTLE_CYC-1, then goes to VALID.
- VALID: o_valid=1, o_busy=0.
- Trim capture (any state):
  - i_trim_we latches i_trim into the trim register.
  - In VALID or SETTLE, a capture goes to SETTLE with the counter cleared; a write during SETTLE restarts the count.
  - In START, the code is captured and START continues without restarting.
  - In OFF, the code is captured only.
- Mode decode, registered: o_sw1 = (mode==1), o_sw2 = (mode!=2).
  - Any change of decoded mode has the same effect as a trim write.
  - Simultaneous trim write and mode change produce a single re-settle.
- o_valid drops on the same edge that enters SETTLE or OFF; it is never high while counting.
- i_en=0 in any state goes to OFF next edge: o_bg_en=0, o_valid=0, counter cleared. This has priority over trim or mode events in the same cycle.
- o_trim follows the trim register with one cycle latency (without the option below).
- Counter saturates and never wraps. Parameters with value 0 or 1 give a one-cycle stay in that state.
- Asynchronous reset mid-sequence returns immediately to the reset values.

Optional Feature:
- Macro VREF_SEQ_SOFTSTART_EN.
- Defined:
  - o_trim steps one LSB toward the trim register every RAMP_CYC cycles.
  - SETTLE/START completion additionally requires o_trim == target.
  - On entering OFF, o_trim resets to 8'h80.
  - A new write during a ramp retargets from the current o_trim.
- Undefined: o_trim jumps directly, as above. RAMP_CYC is unused.

Decomposition:
- Package vref_seq_pkg holds:
  - the state enum and encodings;
  - the mode constants MODE_BG_BUF, MODE_EXT_BUF, MODE_IOUT;
  - TRIM_RESET=8'h80.
- One sub-module, vref_trim_ramp: the soft-start stepper with a ramp counter and up/down compare, plus a passthrough when the option is off.

Test Plan:
- Reset, then i_en=1 with START_CYC=1024: o_bg_en=1 next edge, o_valid=1 exactly 1024 cycles later, o_trim=8'h80.
- In VALID, trim write 8'h5A: o_valid=0 next edge, o_trim=8'h5A, o_valid=1 after 256 cycles.
- Trim write at settle cycle 200, then another at cycle 100 of the new count: valid 256 cycles after the last write only.
- Mode sequence 0 → 1 → 2 → 3: (sw1, sw2) = (0,1), (1,1), (0,0), (0,1). Each change causes a re-settle, except 2 → 3? No: 2 → 3 changes the decode, so it re-settles. 3 → 0 causes no re-settle.
- i_en=0 during START at cycle 500, together with a trim write: OFF next edge, o_bg_en=0, trim stored. Re-enable: full 1024-cycle START.
- With VREF_SEQ_SOFTSTART_EN, write 8'h84 from 8'h80 with RAMP_CYC=16: o_trim increments every 16 cycles, reaches 8'h84 at cycle 64, o_valid held low until then and until the settle count completes.
